lap_ctrl: RTL and testbench
===========================

// Module: lap_ctrl
// PURPOSE
//  Lap/split controller between time_core and display_mux. Captures the live
//  MM:SS digits on each LAP press into a DEPTH-entry circular buffer. Decides
//  what display_mux shows: live time, a frozen split for HOLD_SEC seconds, or
//  stored laps browsed with RECALL while paused.
// PARAMETERS
//  DEPTH     4  stored laps; power of 2, >=2
//  HOLD_SEC  5  tick_1hz periods a split/recall view persists; >=1
// PORTS
//  clk           in   1  system clock (100 MHz)
//  rst_n         in   1  synchronous reset, active-low
//  tick_1hz      in   1  one-cycle strobe, 1 Hz
//  count_enable  in   1  from control_fsm; 1=running, 0=paused
//  lap_pulse     in   1  one-cycle LAP press (debounced + edge_detect)
//  recall_pulse  in   1  one-cycle RECALL press
//  clr_pulse     in   1  one-cycle clear-laps request
//  mt,mo,st,so   in   4  live BCD digits from time_core
//  d_mt,d_mo,d_st,d_so out 4  digits to display_mux
//  lap_active    out  1  1 when state != LIVE (drives dp)
//  lap_idx       out  3  lap shown in RECALL: 1=newest..DEPTH; else 0
//  lap_count     out  3  stored laps, 0..DEPTH, saturating
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=LIVE, wr_ptr=0, lap_count=0, hold=0,
//  lap_idx=0, lap_active=0, d_*=0. Buffer RAM is not cleared.
//  All outputs registered. Every input event changes outputs on the next edge.
//  Priority per cycle: rst_n > clr_pulse > lap_pulse > recall_pulse > tick_1hz.
//  LIVE:
//  - d_* <= live digits.
//  - lap_pulse & count_enable: buf[wr_ptr]<=live; wr_ptr<=wr_ptr+1 mod DEPTH;
//    lap_count<=min(lap_count+1,DEPTH); d_*<=captured; hold<=HOLD_SEC; ->SPLIT.
//  - lap_pulse & !count_enable: ignored.
//  - recall_pulse & !count_enable & lap_count>0: rd=0; d_*<=buf[wr_ptr-1];
//    lap_idx<=1; hold<=HOLD_SEC; ->RECALL. Otherwise recall_pulse ignored.
//  SPLIT:
//  - d_* hold the captured lap.
//  - lap_pulse (running): capture again as in LIVE; hold reloads.
//    Same-cycle tick_1hz is then ignored.
//  - tick_1hz: hold--; on the tick that sees hold==1, ->LIVE.
//  - count_enable=0: stays until the timeout.
//  - recall_pulse ignored.
//  RECALL:
//  - recall_pulse: if rd+1==lap_count ->LIVE (lap_idx<=0). Else rd++;
//    d_*<=buf[(wr_ptr-1-rd) mod DEPTH]; lap_idx<=rd+1; hold reloads.
//  - tick_1hz timeout as in SPLIT.
//  - count_enable=1 (resume): ->LIVE next edge.
//  - lap_pulse ignored.
//  clr_pulse (any state): ->LIVE, wr_ptr=0, lap_count=0, lap_idx=0.
//  After DEPTH laps, each new lap overwrites the oldest. lap_count stays DEPTH.
//  Pointer arithmetic is modulo DEPTH (log2 DEPTH bits, natural wrap).
//  lap_active = (state!=LIVE), registered with the state.
// TESTING
//  1 Live 01:23, count_enable=1, lap_pulse
//    -> next edge d_*=0,1,2,3, lap_active=1, lap_count=1;
//       after 5 tick_1hz, LIVE tracking live digits.
//  2 Laps at 00:10,00:20,00:30,00:40,00:50 (DEPTH=4)
//    -> lap_count=4; pause; recall x4 shows 00:50,00:40,00:30,00:20
//       (lap_idx 1..4); 5th recall -> LIVE, lap_idx=0.
//  3 Paused, lap_count=0, recall_pulse -> stays LIVE. Paused lap_pulse -> no capture.
//  4 In SPLIT with hold=1: lap_pulse and tick_1hz same cycle
//    -> new capture, stays SPLIT, full 5 s hold restarts.
//  5 In RECALL: clr_pulse with recall_pulse -> LIVE, lap_count=0.
//    Separately, count_enable 0->1 in RECALL -> LIVE next edge.
//  6 rst_n=0 for 1 cycle mid-SPLIT -> all outputs 0, LIVE; async glitch on
//    rst_n between edges has no effect.

Source files
------------

// File: rtl/lap_ctrl.sv
// lap_ctrl: lap/split controller sitting between time_core and display_mux.
// Captures live MM:SS digits into a circular lap buffer and selects what the
// display shows: live time, a frozen split, or stored laps browsed while paused.
module lap_ctrl #(
  parameter int DEPTH    = 4,
  parameter int HOLD_SEC = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       count_enable,
  input  logic       lap_pulse,
  input  logic       recall_pulse,
  input  logic       clr_pulse,
  input  logic [3:0] mt,
  input  logic [3:0] mo,
  input  logic [3:0] st,
  input  logic [3:0] so,
  output logic [3:0] d_mt,
  output logic [3:0] d_mo,
  output logic [3:0] d_st,
  output logic [3:0] d_so,
  output logic       lap_active,
  output logic [2:0] lap_idx,
  output logic [2:0] lap_count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int HOLD_W = $clog2(HOLD_SEC + 1);

  typedef enum logic [1:0] {LIVE, SPLIT, RECALL} state_t;

  state_t             state;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd;
  logic [PTR_W-1:0]   rd_next;
  logic [PTR_W-1:0]   rd_addr;
  logic [HOLD_W-1:0]  hold;
  logic [15:0]        lap_mem [DEPTH];
  logic [15:0]        live_p0;
  logic [15:0]        disp;
  logic               capture;

  assign live_p0 = {mt, mo, st, so};
  assign {d_mt, d_mo, d_st, d_so} = disp;

  // A running LAP press captures from LIVE or SPLIT; it is dead in RECALL
  // and loses to a same-cycle clear.
  assign capture = lap_pulse & count_enable & (state != RECALL) & ~clr_pulse;

  // Entering RECALL starts at the newest lap; each further press steps one older.
  assign rd_next = (state == RECALL) ? rd + PTR_W'(1) : '0;
  assign rd_addr = wr_ptr - PTR_W'(1) - rd_next;

  // Lap storage: written on capture only, deliberately never cleared.
  always_ff @(posedge clk) begin
    if (rst_n && capture) begin
      lap_mem[wr_ptr] <= live_p0;
    end
  end

  // Mode FSM with registered display digits and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= LIVE;
      wr_ptr     <= '0;
      rd         <= '0;
      hold       <= '0;
      lap_count  <= '0;
      lap_idx    <= '0;
      lap_active <= 1'b0;
      disp       <= '0;
    end else if (clr_pulse) begin
      state      <= LIVE;
      wr_ptr     <= '0;
      rd         <= '0;
      hold       <= '0;
      lap_count  <= '0;
      lap_idx    <= '0;
      lap_active <= 1'b0;
      disp       <= live_p0;
    end else if (capture) begin
      wr_ptr     <= wr_ptr + PTR_W'(1);
      lap_count  <= (lap_count == 3'(DEPTH)) ? lap_count : lap_count + 3'd1;
      disp       <= live_p0;
      hold       <= HOLD_W'(HOLD_SEC);
      lap_idx    <= '0;
      lap_active <= 1'b1;
      state      <= SPLIT;
    end else begin
      case (state)
        LIVE: begin
          disp <= live_p0;
          if (recall_pulse && !count_enable && lap_count != 3'd0) begin
            rd         <= '0;
            disp       <= lap_mem[rd_addr];
            lap_idx    <= 3'd1;
            hold       <= HOLD_W'(HOLD_SEC);
            lap_active <= 1'b1;
            state      <= RECALL;
          end
        end
        SPLIT: begin
          if (tick_1hz) begin
            if (hold == HOLD_W'(1)) begin
              state      <= LIVE;
              lap_active <= 1'b0;
              lap_idx    <= '0;
              hold       <= '0;
              disp       <= live_p0;
            end else begin
              hold <= hold - HOLD_W'(1);
            end
          end
        end
        RECALL: begin
          if (count_enable) begin
            state      <= LIVE;
            lap_active <= 1'b0;
            lap_idx    <= '0;
            hold       <= '0;
            disp       <= live_p0;
          end else if (recall_pulse) begin
            if (3'(rd) + 3'd1 == lap_count) begin
              state      <= LIVE;
              lap_active <= 1'b0;
              lap_idx    <= '0;
              hold       <= '0;
              disp       <= live_p0;
            end else begin
              rd      <= rd_next;
              disp    <= lap_mem[rd_addr];
              lap_idx <= 3'(rd_next) + 3'd1;
              hold    <= HOLD_W'(HOLD_SEC);
            end
          end else if (tick_1hz) begin
            if (hold == HOLD_W'(1)) begin
              state      <= LIVE;
              lap_active <= 1'b0;
              lap_idx    <= '0;
              hold       <= '0;
              disp       <= live_p0;
            end else begin
              hold <= hold - HOLD_W'(1);
            end
          end
        end
        default: begin
          state      <= LIVE;
          lap_active <= 1'b0;
          lap_idx    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lap_ctrl.sv
// Testbench for lap_ctrl: directed scenarios plus randomized traffic, all
// checked against a queue-based behavioural model of the lap controller.
module tb_lap_ctrl;

  localparam int DEPTH    = 4;
  localparam int HOLD_SEC = 5;

  logic       clk;
  logic       rst_n;
  logic       tick_1hz;
  logic       count_enable;
  logic       lap_pulse;
  logic       recall_pulse;
  logic       clr_pulse;
  logic [3:0] mt, mo, st, so;
  logic [3:0] d_mt, d_mo, d_st, d_so;
  logic       lap_active;
  logic [2:0] lap_idx;
  logic [2:0] lap_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: laps held newest-first in a queue.
  int          m_mode;   // 0 live, 1 split, 2 recall
  int          m_hold;
  int          m_pos;
  int          m_idx;
  logic [15:0] m_disp;
  logic [15:0] m_laps [$];

  lap_ctrl #(.DEPTH(DEPTH), .HOLD_SEC(HOLD_SEC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_1hz     (tick_1hz),
    .count_enable (count_enable),
    .lap_pulse    (lap_pulse),
    .recall_pulse (recall_pulse),
    .clr_pulse    (clr_pulse),
    .mt           (mt),
    .mo           (mo),
    .st           (st),
    .so           (so),
    .d_mt         (d_mt),
    .d_mo         (d_mo),
    .d_st         (d_st),
    .d_so         (d_so),
    .lap_active   (lap_active),
    .lap_idx      (lap_idx),
    .lap_count    (lap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] rand_live();
    logic [15:0] v;
    v = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
         4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
    return v;
  endfunction

  task automatic go_live_model(input logic [15:0] live);
    m_mode = 0;
    m_idx  = 0;
    m_disp = live;
  endtask

  // One clock of the reference model, from the rules of the lap controller.
  task automatic model_step(input logic r, input logic en, input logic lap,
                            input logic rec, input logic clr, input logic tk,
                            input logic [15:0] live);
    if (!r) begin
      m_laps.delete();
      m_mode = 0; m_hold = 0; m_idx = 0; m_disp = 16'h0000;
    end else if (clr) begin
      m_laps.delete();
      go_live_model(live);
    end else if (lap && en && m_mode != 2) begin
      m_laps.push_front(live);
      if (m_laps.size() > DEPTH) void'(m_laps.pop_back());
      m_disp = live; m_hold = HOLD_SEC; m_mode = 1; m_idx = 0;
    end else if (m_mode == 0) begin
      m_disp = live;
      if (rec && !en && m_laps.size() > 0) begin
        m_pos = 0; m_disp = m_laps[0]; m_idx = 1; m_hold = HOLD_SEC; m_mode = 2;
      end
    end else if (m_mode == 1) begin
      if (tk) begin
        m_hold--;
        if (m_hold == 0) go_live_model(live);
      end
    end else begin
      if (en) go_live_model(live);
      else if (rec) begin
        if (m_pos + 1 == m_laps.size()) go_live_model(live);
        else begin
          m_pos++; m_disp = m_laps[m_pos]; m_idx = m_pos + 1; m_hold = HOLD_SEC;
        end
      end else if (tk) begin
        m_hold--;
        if (m_hold == 0) go_live_model(live);
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, and compare all outputs.
  task automatic cycle(input logic r, input logic en, input logic lap,
                       input logic rec, input logic clr, input logic tk,
                       input logic [15:0] live, input bit glitch);
    @(negedge clk);
    rst_n = r; count_enable = en; lap_pulse = lap; recall_pulse = rec;
    clr_pulse = clr; tick_1hz = tk; {mt, mo, st, so} = live;
    if (glitch) begin
      #1 rst_n = 1'b0;
      #1 rst_n = 1'b1;
    end
    model_step(r, en, lap, rec, clr, tk, live);
    @(posedge clk);
    #1;
    chk("disp",   32'({d_mt, d_mo, d_st, d_so}), 32'(m_disp));
    chk("active", 32'(lap_active), 32'(m_mode != 0));
    chk("idx",    32'(lap_idx), 32'(m_idx));
    chk("count",  32'(lap_count), 32'(m_laps.size()));
  endtask

  initial begin
    logic [15:0] lv;
    logic        en;
    rst_n = 1'b0; count_enable = 1'b0; lap_pulse = 1'b0; recall_pulse = 1'b0;
    clr_pulse = 1'b0; tick_1hz = 1'b0; {mt, mo, st, so} = 16'h0000;
    m_mode = 0; m_hold = 0; m_pos = 0; m_idx = 0; m_disp = 16'h0000;

    // Reset state
    cycle(0, 0, 0, 0, 0, 0, 16'h0123, 0);
    chk("rst_disp", 32'({d_mt, d_mo, d_st, d_so}), 32'h0);
    chk("rst_active", 32'(lap_active), 32'h0);

    // Scenario 1: capture 01:23, hold for five ticks, then back to live
    cycle(1, 1, 0, 0, 0, 0, 16'h0123, 0);
    cycle(1, 1, 1, 0, 0, 0, 16'h0123, 0);
    chk("s1_cap", 32'({d_mt, d_mo, d_st, d_so}), 32'h0123);
    chk("s1_act", 32'(lap_active), 32'h1);
    chk("s1_cnt", 32'(lap_count), 32'h1);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 0, 1, 16'h0124 + 16'(i), 0);
    chk("s1_hold", 32'(lap_active), 32'h1);
    cycle(1, 1, 0, 0, 0, 1, 16'h0130, 0);
    chk("s1_timeout", 32'(lap_active), 32'h0);
    cycle(1, 1, 0, 0, 0, 0, 16'h0131, 0);
    chk("s1_live", 32'({d_mt, d_mo, d_st, d_so}), 32'h0131);

    // Scenario 2: five laps overwrite the oldest; recall browses newest-first
    cycle(1, 1, 0, 0, 1, 0, 16'h0000, 0);
    for (int i = 1; i <= 5; i++) begin
      cycle(1, 1, 1, 0, 0, 0, 16'(i) << 4, 0);
      cycle(1, 1, 0, 0, 0, 0, 16'h0055, 0);
    end
    chk("s2_cnt", 32'(lap_count), 32'h4);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0, 1, 16'h0055, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0, 1, 0, 0, 16'h0055, 0);
      chk("s2_rec", 32'({d_mt, d_mo, d_st, d_so}), 32'(16'h0050 - 16'(i * 16)));
      chk("s2_idx", 32'(lap_idx), 32'(i + 1));
    end
    cycle(1, 0, 0, 1, 0, 0, 16'h0055, 0);
    chk("s2_exit_act", 32'(lap_active), 32'h0);
    chk("s2_exit_idx", 32'(lap_idx), 32'h0);

    // Scenario 3: paused with no laps, recall and lap are both ignored
    cycle(1, 0, 0, 0, 1, 0, 16'h0200, 0);
    cycle(1, 0, 0, 1, 0, 0, 16'h0200, 0);
    chk("s3_norec", 32'(lap_active), 32'h0);
    cycle(1, 0, 1, 0, 0, 0, 16'h0201, 0);
    chk("s3_nocap", 32'(lap_count), 32'h0);

    // Scenario 4: lap and final tick together restart the full hold
    cycle(1, 1, 1, 0, 0, 0, 16'h0300, 0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 0, 1, 16'h0301, 0);
    cycle(1, 1, 1, 0, 0, 1, 16'h0302, 0);
    chk("s4_recap", 32'({d_mt, d_mo, d_st, d_so}), 32'h0302);
    chk("s4_stay", 32'(lap_active), 32'h1);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 0, 1, 16'h0303, 0);
    chk("s4_hold", 32'(lap_active), 32'h1);
    cycle(1, 1, 0, 0, 0, 1, 16'h0304, 0);
    chk("s4_timeout", 32'(lap_active), 32'h0);

    // Scenario 5: clear beats recall in RECALL; resume leaves RECALL
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0, 1, 16'h0400, 0);
    cycle(1, 0, 0, 1, 0, 0, 16'h0400, 0);
    chk("s5_inrec", 32'(lap_active), 32'h1);
    cycle(1, 0, 0, 1, 1, 0, 16'h0401, 0);
    chk("s5_clr_act", 32'(lap_active), 32'h0);
    chk("s5_clr_cnt", 32'(lap_count), 32'h0);
    cycle(1, 1, 1, 0, 0, 0, 16'h0410, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0, 1, 16'h0411, 0);
    cycle(1, 0, 0, 1, 0, 0, 16'h0411, 0);
    chk("s5_rec2", 32'({d_mt, d_mo, d_st, d_so}), 32'h0410);
    cycle(1, 1, 0, 0, 0, 0, 16'h0412, 0);
    chk("s5_resume", 32'(lap_active), 32'h0);

    // Scenario 6: glitch between edges is ignored, sampled reset clears all
    cycle(1, 1, 1, 0, 0, 0, 16'h0500, 0);
    cycle(1, 1, 0, 0, 0, 0, 16'h0501, 1);
    chk("s6_glitch", 32'(lap_active), 32'h1);
    cycle(0, 1, 0, 0, 0, 0, 16'h0502, 0);
    chk("s6_rst_disp", 32'({d_mt, d_mo, d_st, d_so}), 32'h0);
    chk("s6_rst_cnt", 32'(lap_count), 32'h0);
    chk("s6_rst_act", 32'(lap_active), 32'h0);

    // Randomized traffic
    en = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 15) == 0) en = ~en;
      lv = rand_live();
      cycle(($urandom_range(0, 299) != 0), en,
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 79) == 0), ($urandom_range(0, 3) == 0),
            lv, ($urandom_range(0, 49) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
